register_file_multiport: RTL and testbench



---
 rtl/register_file_multiport_pkg.sv | 14 +
 rtl/register_file_multiport_if.sv | 28 ++
 rtl/register_file_multiport_clear_sequencer.sv | 56 +++++
 rtl/register_file_multiport.sv | 79 +++++++
 tb/tb_register_file_multiport.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_multiport_pkg.sv
// Shared types and default widths for the multiport register file.
// Sweep FSM states plus the 32 x 32, two-read-port default geometry.
package register_file_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_READ_PORTS = 2;

endpackage

// File: rtl/register_file_multiport_if.sv
// Decode/writeback bus of the register file: clear request, write port, read ports.
// Master drives requests and addresses; slave returns status and read data.
interface register_file_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2
);

  logic                             clear;
  logic                             busy;
  logic                             write_enable;
  logic [ADDR_WIDTH-1:0]            write_address;
  logic [DATA_WIDTH-1:0]            write_data;
  logic                             write_dropped;
  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address;
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data;

  modport master (
    output clear, write_enable, write_address, write_data, read_address,
    input  busy, write_dropped, read_data
  );

  modport slave (
    input  clear, write_enable, write_address, write_data, read_address,
    output busy, write_dropped, read_data
  );

endinterface

// File: rtl/register_file_multiport_clear_sequencer.sv
// Zeroing sweep: one entry per edge after reset or an idle-time clear request.
// Busy for exactly 2**ADDR_WIDTH edges; clear during a sweep is ignored.
module register_file_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  rf_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEARING;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEARING;
          ptr_d   = '0;
        end
      end
      CLEARING: begin
        // Pointer wraps to 0 on the last entry, ready for the next sweep.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == CLEARING);
    clr_we_o   = (state_q == CLEARING);
    clr_addr_o = ptr_q;
  end

endmodule

// File: rtl/register_file_multiport.sv
// Register file: one write port, READ_PORTS combinational read ports with write-through bypass.
// Write visible next edge (same cycle via bypass); writes during a sweep are dropped and flagged.
module register_file_multiport
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  register_file_multiport_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  busy;
  logic                  seq_we;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  zero_wr;
  logic                  user_wr;
  logic                  dropped_q, dropped_d;

  register_file_clear_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (bus.clear),
    .busy_o     (busy),
    .clr_we_o   (seq_we),
    .clr_addr_o (seq_addr)
  );

  assign zero_wr = (ZERO_REG != 0) && (bus.write_address == '0);
  assign user_wr = bus.write_enable && !bus.clear && !busy;

  // Storage is deliberately unreset; the sweep zeroes it after reset.
  always_ff @(posedge clock) begin
    if (seq_we) begin
      mem_q[seq_addr] <= '0;
    end else if (user_wr && !zero_wr) begin
      mem_q[bus.write_address] <= bus.write_data;
    end
  end

  assign dropped_d = bus.write_enable && (busy || bus.clear) && !zero_wr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dropped_q <= 1'b0;
    else          dropped_q <= dropped_d;
  end

  assign bus.busy          = busy;
  assign bus.write_dropped = dropped_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = mem_q[ra];
      if (busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if (bus.write_enable && !bus.clear && (bus.write_address == ra)) begin
        rd = bus.write_data;
      end
    end

    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Scoreboard bench: stimulus queues expectations stamped with a cycle number,
// a negedge monitor compares every expectation due in the current cycle.
module tb_register_file_multiport;

  typedef struct {
    int          cyc;
    int          dut;   // 0: 32x32/2 ports, 1: 8x16/4 ports
    int          kind;  // 0: read port, 1: busy, 2: write_dropped
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [31:0] act;

  register_file_multiport_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2)) ifa ();
  register_file_multiport_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4)) ifb ();

  register_file_multiport #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  register_file_multiport #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4), .ZERO_REG(1)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int dut, int kind, int idx);
    if (dut == 0) begin
      case (kind)
        0:       return ifa.read_data[idx*32 +: 32];
        1:       return {31'b0, ifa.busy};
        default: return {31'b0, ifa.write_dropped};
      endcase
    end else begin
      case (kind)
        0:       return 32'(ifb.read_data[idx*16 +: 16]);
        1:       return {31'b0, ifb.busy};
        default: return {31'b0, ifb.write_dropped};
      endcase
    end
  endfunction

  task automatic push(int c, int dut, int kind, int idx, logic [31:0] exp, string name);
    exp_t e;
    e.cyc = c; e.dut = dut; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].dut, sb[i].kind, sb[i].idx);
        n_tests++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s dut=%0d port=%0d cyc=%0d got=%h want=%h",
                   sb[i].name, sb[i].dut, sb[i].idx, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int c0;
    int ck;
    reset_n = 1'b0;
    ifa.clear = 0; ifa.write_enable = 0; ifa.write_address = '0; ifa.write_data = '0; ifa.read_address = '0;
    ifb.clear = 0; ifb.write_enable = 0; ifb.write_address = '0; ifb.write_data = '0; ifb.read_address = '0;
    tick(); tick();

    push(cyc, 0, 1, 0, 32'd1, "rst_busy");
    push(cyc, 0, 2, 0, 32'd0, "rst_dropped");
    push(cyc, 0, 0, 0, 32'd0, "rst_read");
    push(cyc, 1, 1, 0, 32'd1, "rst_busy_b");
    reset_n = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 32; k++) push(c0 + k, 0, 1, 0, 32'd1, "sweep_busy");
    push(c0 + 32, 0, 1, 0, 32'd0, "sweep_done");
    for (int k = 0; k < 8; k++) push(c0 + k, 1, 1, 0, 32'd1, "sweep_busy_b");
    push(c0 + 8, 1, 1, 0, 32'd0, "sweep_done_b");

    // Write to r7 while the post-reset sweep is running
    tick(); tick(); tick();
    ifa.write_enable = 1; ifa.write_address = 5'd7; ifa.write_data = 32'h77; ifa.read_address = {5'd7, 5'd7};
    push(cyc, 0, 0, 0, 32'd0, "rd_while_busy");
    push(cyc, 0, 2, 0, 32'd0, "drop_not_yet");
    push(cyc + 1, 0, 2, 0, 32'd1, "drop_pulse");
    push(cyc + 2, 0, 2, 0, 32'd0, "drop_one_cycle");
    tick();
    ifa.write_enable = 0;
    while (cyc < c0 + 32) tick();

    #1;
    n_tests++;
    if (ifa.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL direct_sweep_done got=%b", ifa.busy);
    end
    n_tests++;
    if (ifa.write_dropped !== 1'b0) begin
        n_fail++;
        $display("FAIL direct_no_drop got=%b", ifa.write_dropped);
    end

    for (int a = 0; a < 32; a++) begin
      ifa.read_address = {5'(31 - a), 5'(a)};
      push(cyc, 0, 0, 0, 32'd0, "post_reset_p0");
      push(cyc, 0, 0, 1, 32'd0, "post_reset_p1");
      tick();
    end

    ifa.write_enable = 1; ifa.write_address = 5'd5; ifa.write_data = 32'hDEADBEEF;
    ifa.read_address = {5'd5, 5'd3};
    push(cyc, 0, 0, 1, 32'hDEADBEEF, "bypass_p1");
    push(cyc, 0, 0, 0, 32'd0, "other_p0");
    tick();
    ifa.write_enable = 0; ifa.read_address = {5'd3, 5'd5};
    push(cyc, 0, 0, 0, 32'hDEADBEEF, "wr_r5");
    push(cyc, 0, 2, 0, 32'd0, "wr_no_drop");
    tick();

    ifa.write_enable = 1; ifa.write_address = 5'd0; ifa.write_data = 32'h12345678;
    ifa.read_address = {5'd0, 5'd0};
    push(cyc, 0, 0, 0, 32'd0, "zero_same_p0");
    push(cyc, 0, 0, 1, 32'd0, "zero_same_p1");
    tick();
    ifa.write_enable = 0;
    push(cyc, 0, 0, 0, 32'd0, "zero_after");
    push(cyc, 0, 2, 0, 32'd0, "zero_no_drop");
    tick();

    for (int a = 1; a < 32; a++) begin
      ifa.write_enable = 1; ifa.write_address = 5'(a); ifa.write_data = 32'(a);
      tick();
    end
    ifa.write_enable = 0; ifa.read_address = {5'd17, 5'd31};
    push(cyc, 0, 0, 0, 32'd31, "fill_r31");
    push(cyc, 0, 0, 1, 32'd17, "fill_r17");
    tick();

    // Clear together with a write: write dropped, bypass suppressed
    ifa.clear = 1; ifa.write_enable = 1; ifa.write_address = 5'd9; ifa.write_data = 32'hAAAA;
    ifa.read_address = {5'd5, 5'd9};
    ck = cyc;
    push(ck, 0, 0, 0, 32'd9, "clr_no_bypass");
    push(ck, 0, 0, 1, 32'd5, "clr_r5_stored");
    push(ck, 0, 1, 0, 32'd0, "clr_busy_before");
    push(ck + 1, 0, 2, 0, 32'd1, "clr_drop");
    push(ck + 2, 0, 2, 0, 32'd0, "clr_drop_one");
    for (int k = 1; k <= 32; k++) push(ck + k, 0, 1, 0, 32'd1, "clr_busy");
    push(ck + 33, 0, 1, 0, 32'd0, "clr_done");
    tick();
    ifa.clear = 0; ifa.write_enable = 0; ifa.read_address = {5'd1, 5'd31};
    for (int j = 1; j <= 32; j++) begin
      ifa.clear = (j == 10);
      push(cyc, 0, 0, 0, 32'd0, "clr_rd_during");
      tick();
    end
    ifa.clear = 0;
    for (int a = 0; a < 32; a++) begin
      ifa.read_address = {5'(31 - a), 5'(a)};
      push(cyc, 0, 0, 0, 32'd0, "post_clear_p0");
      push(cyc, 0, 0, 1, 32'd0, "post_clear_p1");
      tick();
    end

    ifb.write_enable = 1; ifb.write_address = 3'd3; ifb.write_data = 16'hBEEF;
    ifb.read_address = {4{3'd3}};
    for (int p = 0; p < 4; p++) push(cyc, 1, 0, p, 32'h0000BEEF, "b_bypass");
    tick();
    ifb.write_enable = 0;
    for (int p = 0; p < 4; p++) push(cyc, 1, 0, p, 32'h0000BEEF, "b_read");
    push(cyc, 1, 2, 0, 32'd0, "b_no_drop");
    tick();
    ifb.read_address = {3'd2, 3'd3, 3'd0, 3'd3};
    push(cyc, 1, 0, 0, 32'h0000BEEF, "b_mix_p0");
    push(cyc, 1, 0, 1, 32'd0, "b_mix_p1");
    push(cyc, 1, 0, 3, 32'd0, "b_mix_p3");
    tick(); tick();

    #1;
    n_tests++;
    if (ifb.read_data[15:0] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL direct_b_p0 got=%h", ifb.read_data[15:0]);
    end
    n_tests++;
    if (ifb.read_data[47:32] !== 16'hBEEF) begin
        n_fail++;
        $display("FAIL direct_b_p2 got=%h", ifb.read_data[47:32]);
    end

    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL unchecked %s cyc=%0d want=%h", sb[i].name, sb[i].cyc, sb[i].exp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
